// File: rtl/npu_image_sequencer.sv
// rtl/npu_image_sequencer.sv - frame buffer, NPU reset/stream sequencer and decision scoring
module npu_image_sequencer #(
    parameter int NPIX       = 784,
    parameter int DATA_BITS  = 8,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4095,
    parameter int CNT_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 start,
    input  logic [3:0]           label_in,
    input  logic                 clear_stats,
    output logic                 npu_rst_n,
    output logic [DATA_BITS-1:0] pix_out,
    input  logic                 dec_valid,
    input  logic [3:0]           dec_class,
    output logic                 busy,
    output logic                 res_valid,
    output logic [3:0]           res_class,
    output logic                 res_hit,
    output logic                 res_timeout,
    output logic [CNT_BITS-1:0]  img_cnt,
    output logic [CNT_BITS-1:0]  hit_cnt
);

    localparam int AW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [AW-1:0] LAST_PIX  = AW'(NPIX - 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RST_LOAD  = RW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHIP_RST,
        S_STREAM,
        S_WAIT_DEC,
        S_REPORT
    } state_t;

    state_t state, state_nx;

    logic [DATA_BITS-1:0] mem [NPIX];
    logic [DATA_BITS-1:0] rd_q;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        pix_cnt;
    logic [AW-1:0]        rd_addr;
    logic [RW-1:0]        rst_cnt;
    logic [TW-1:0]        wait_cnt;
    logic [3:0]           label_q;
    logic                 loaded;
    logic                 ready_en;
    logic                 wr_fire;
    logic                 start_ok;
    logic                 dec_fire;
    logic                 to_fire;

    // ready_en keeps wr_ready low while rst_n is asserted and rises on the first clock after release
    always_comb begin
        wr_ready = ready_en && (state == S_IDLE) && !loaded;
        wr_fire  = wr_valid && wr_ready;
        start_ok = (state == S_IDLE) && start && loaded;
        dec_fire = (state == S_WAIT_DEC) && dec_valid;
        to_fire  = (state == S_WAIT_DEC) && !dec_valid && (wait_cnt == LAST_WAIT);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (start_ok) state_nx = S_CHIP_RST;
            S_CHIP_RST: if (rst_cnt == '0) state_nx = S_STREAM;
            S_STREAM:   if (pix_cnt == LAST_PIX) state_nx = S_WAIT_DEC;
            S_WAIT_DEC: if (dec_fire || to_fire) state_nx = S_REPORT;
            S_REPORT:   state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Read runs one cycle ahead of the stream: address 0 is fetched in every CHIP_RST cycle
    always_comb begin
        npu_rst_n = (state == S_STREAM) || (state == S_WAIT_DEC) || (state == S_REPORT);
        pix_out   = (state == S_STREAM) ? rd_q : '0;
        busy      = (state == S_CHIP_RST) || (state == S_STREAM) || (state == S_WAIT_DEC);
        res_valid = (state == S_REPORT);
        rd_addr   = '0;
        if (state == S_STREAM && pix_cnt != LAST_PIX) begin
            rd_addr = pix_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ready_en <= 1'b0;
            wr_addr  <= '0;
            loaded   <= 1'b0;
            label_q  <= '0;
            rst_cnt  <= '0;
            pix_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            ready_en <= 1'b1;

            if (wr_fire) begin
                if (wr_addr == LAST_PIX) begin
                    wr_addr <= '0;
                    loaded  <= 1'b1;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
            if (state == S_REPORT) begin
                loaded <= 1'b0;
            end

            if (start_ok) begin
                label_q <= label_in;
                rst_cnt <= RST_LOAD;
            end else if (state == S_CHIP_RST && rst_cnt != '0) begin
                rst_cnt <= rst_cnt - 1'b1;
            end

            if (state == S_STREAM && pix_cnt != LAST_PIX) begin
                pix_cnt <= pix_cnt + 1'b1;
            end else begin
                pix_cnt <= '0;
            end

            if (state == S_WAIT_DEC) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_class   <= '0;
            res_hit     <= 1'b0;
            res_timeout <= 1'b0;
        end else if (dec_fire) begin
            res_class   <= dec_class;
            res_hit     <= (dec_class == label_q);
            res_timeout <= 1'b0;
        end else if (to_fire) begin
            res_class   <= 4'hF;
            res_hit     <= 1'b0;
            res_timeout <= 1'b1;
        end
    end

    // A clear coincident with REPORT wipes the old totals, then the current result still counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_cnt <= '0;
            hit_cnt <= '0;
        end else if (state == S_REPORT) begin
            if (clear_stats) begin
                img_cnt <= CNT_BITS'(1);
                hit_cnt <= CNT_BITS'(res_hit);
            end else begin
                if (img_cnt != '1) begin
                    img_cnt <= img_cnt + 1'b1;
                end
                if (res_hit && hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + 1'b1;
                end
            end
        end else if (clear_stats) begin
            img_cnt <= '0;
            hit_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_npu_image_sequencer.sv
// tb/tb_npu_image_sequencer.sv - scoreboard bench for npu_image_sequencer
module tb_npu_image_sequencer;

    localparam int NPIX = 784;
    localparam int DB   = 8;
    localparam int RSTC = 2;
    localparam int TO   = 4095;
    localparam int CB   = 2;
    localparam int CMAX = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DB-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [3:0]    label_in = '0;
    logic          clear_stats = 1'b0;
    logic          npu_rst_n;
    logic [DB-1:0] pix_out;
    logic          dec_valid = 1'b0;
    logic [3:0]    dec_class = '0;
    logic          busy;
    logic          res_valid;
    logic [3:0]    res_class;
    logic          res_hit;
    logic          res_timeout;
    logic [CB-1:0] img_cnt;
    logic [CB-1:0] hit_cnt;

    typedef struct packed {
        logic [3:0] cls;
        logic       hit;
        logic       to;
    } res_t;

    logic [DB-1:0] pix_q[$];
    res_t          res_q[$];
    int            exp_img = 0;
    int            exp_hit = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    npu_image_sequencer #(
        .NPIX(NPIX), .DATA_BITS(DB), .RST_CYCLES(RSTC), .TIMEOUT(TO), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .start(start), .label_in(label_in), .clear_stats(clear_stats),
        .npu_rst_n(npu_rst_n), .pix_out(pix_out),
        .dec_valid(dec_valid), .dec_class(dec_class),
        .busy(busy), .res_valid(res_valid), .res_class(res_class),
        .res_hit(res_hit), .res_timeout(res_timeout),
        .img_cnt(img_cnt), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic load_bytes(input int first, input int n);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < n * 4 + 20) begin
            @(negedge clk);
            guard++;
            if (wr_ready) begin
                wr_valid = 1'b1;
                wr_data  = DB'(first + sent);
                pix_q.push_back(wr_data);
                sent++;
            end else begin
                wr_valid = 1'b0;
            end
        end
        @(negedge clk);
        wr_valid = 1'b0;
        n_checks++;
        if (sent !== n) begin
            n_fail++;
            $display("FAIL load_count: sent %0d required %0d", sent, n);
        end
    endtask

    task automatic run_frame(input logic [3:0] label, input logic [3:0] dcls,
                             input bit timeout, input int d, input bit clr);
        res_t        e;
        logic [DB-1:0] ep;
        int          idx;
        bit          seen;
        e.cls = timeout ? 4'hF : dcls;
        e.to  = timeout;
        e.hit = !timeout && (dcls == label);
        @(negedge clk);
        start = 1'b1;
        label_in = label;
        res_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        label_in = 4'h0;
        n_checks++;
        if (npu_rst_n !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_hold_1: npu_rst_n=%0b busy=%0b required 0/1", npu_rst_n, busy);
        end
        @(negedge clk);
        n_checks++;
        if (npu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold_2: npu_rst_n=%0b required 0", npu_rst_n);
        end
        @(negedge clk);
        for (int k = 0; k < NPIX; k++) begin
            ep = '0;
            if (pix_q.size() > 0) ep = pix_q.pop_front();
            n_checks++;
            if (pix_out !== ep || npu_rst_n !== 1'b1 || wr_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_pix[%0d]: pix=%0h rst_n=%0b wr_ready=%0b required %0h/1/0",
                         k, pix_out, npu_rst_n, wr_ready, ep);
            end
            dec_valid = (k == 100);
            dec_class = 4'h9;
            @(negedge clk);
        end
        dec_valid = 1'b0;
        n_checks++;
        if (pix_out !== '0 || busy !== 1'b1 || npu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_entry: pix=%0h busy=%0b rst_n=%0b required 0/1/1", pix_out, busy, npu_rst_n);
        end
        idx = 0;
        seen = 1'b0;
        while (!seen && idx <= TO + 50) begin
            if (res_valid) begin
                seen = 1'b1;
            end else begin
                dec_valid = !timeout && (idx == d);
                dec_class = dcls;
                idx++;
                @(negedge clk);
            end
        end
        dec_valid = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL no_result: res_valid never seen within %0d cycles", TO + 50);
        end else begin
            if (idx !== (timeout ? TO : d + 1)) begin
                n_fail++;
                $display("FAIL result_latency: %0d cycles into wait required %0d", idx, timeout ? TO : d + 1);
            end
            e = res_q.pop_front();
            n_checks++;
            if (res_class !== e.cls || res_hit !== e.hit || res_timeout !== e.to) begin
                n_fail++;
                $display("FAIL result_fields: class=%0h hit=%0b to=%0b required %0h/%0b/%0b",
                         res_class, res_hit, res_timeout, e.cls, e.hit, e.to);
            end
            clear_stats = clr;
            if (clr) begin
                exp_img = 0;
                exp_hit = 0;
            end
            exp_img = (exp_img + 1 > CMAX) ? CMAX : exp_img + 1;
            exp_hit = (exp_hit + int'(e.hit) > CMAX) ? CMAX : exp_hit + int'(e.hit);
            @(negedge clk);
            clear_stats = 1'b0;
            n_checks++;
            if (res_valid !== 1'b0 || int'(img_cnt) !== exp_img || int'(hit_cnt) !== exp_hit) begin
                n_fail++;
                $display("FAIL counters: res_valid=%0b img=%0d hit=%0d required 0/%0d/%0d",
                         res_valid, img_cnt, hit_cnt, exp_img, exp_hit);
            end
            n_checks++;
            if (wr_ready !== 1'b1 || npu_rst_n !== 1'b0 || busy !== 1'b0 || res_class !== e.cls) begin
                n_fail++;
                $display("FAIL post_report: wr_ready=%0b rst_n=%0b busy=%0b class=%0h required 1/0/0/%0h",
                         wr_ready, npu_rst_n, busy, res_class, e.cls);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (npu_rst_n !== 1'b0 || pix_out !== '0 || wr_ready !== 1'b0 || busy !== 1'b0 ||
            res_valid !== 1'b0 || res_class !== '0 || res_hit !== 1'b0 || res_timeout !== 1'b0 ||
            img_cnt !== '0 || hit_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_values: rst_n=%0b pix=%0h wr_ready=%0b busy=%0b rv=%0b cls=%0h img=%0d hit=%0d required all 0",
                     npu_rst_n, pix_out, wr_ready, busy, res_valid, res_class, img_cnt, hit_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: wr_ready=%0b busy=%0b required 1/0", wr_ready, busy);
        end
    endtask

    task automatic test_basic_hit;
        load_bytes(0, NPIX);
        run_frame(4'd2, 4'd2, 1'b0, 49, 1'b0);
    endtask

    task automatic test_miss;
        load_bytes(0, NPIX);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_not_ready: wr_ready=%0b required 0", wr_ready);
        end
        wr_valid = 1'b0;
        run_frame(4'd7, 4'd3, 1'b0, 49, 1'b0);
    endtask

    task automatic test_timeout;
        load_bytes(0, NPIX);
        run_frame(4'd6, 4'd0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_saturation;
        for (int r = 0; r < 2; r++) begin
            load_bytes(r * 91, NPIX);
            run_frame(4'(r + 1), 4'(r + 1), 1'b0, 5 + r, 1'b0);
        end
    endtask

    task automatic test_partial_load;
        load_bytes(0, 500);
        @(negedge clk);
        start = 1'b1;
        label_in = 4'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (npu_rst_n !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL partial_start: rst_n=%0b busy=%0b wr_ready=%0b required 0/0/1",
                         npu_rst_n, busy, wr_ready);
            end
            @(negedge clk);
        end
        load_bytes(500, NPIX - 500);
        run_frame(4'd5, 4'd5, 1'b0, 10, 1'b0);
    endtask

    task automatic test_clear_stats;
        @(negedge clk);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        exp_img = 0;
        exp_hit = 0;
        n_checks++;
        if (img_cnt !== '0 || hit_cnt !== '0) begin
            n_fail++;
            $display("FAIL clear_idle: img=%0d hit=%0d required 0/0", img_cnt, hit_cnt);
        end
        load_bytes(3, NPIX);
        run_frame(4'd4, 4'd4, 1'b0, 30, 1'b1);
    endtask

    task automatic test_reset_mid_stream;
        load_bytes(37, NPIX);
        @(negedge clk);
        start = 1'b1;
        label_in = 4'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        repeat (300) @(negedge clk);
        n_checks++;
        if (npu_rst_n !== 1'b1 || pix_out !== DB'(37 + 300)) begin
            n_fail++;
            $display("FAIL mid_stream_pix: rst_n=%0b pix=%0h required 1/%0h", npu_rst_n, pix_out, DB'(37 + 300));
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (npu_rst_n !== 1'b0 || pix_out !== '0 || wr_ready !== 1'b0 || busy !== 1'b0 ||
            res_valid !== 1'b0 || res_class !== '0 || res_hit !== 1'b0 || res_timeout !== 1'b0 ||
            img_cnt !== '0 || hit_cnt !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_values: rst_n=%0b pix=%0h wr_ready=%0b busy=%0b cls=%0h img=%0d hit=%0d required all 0",
                     npu_rst_n, pix_out, wr_ready, busy, res_class, img_cnt, hit_cnt);
        end
        pix_q.delete();
        res_q.delete();
        exp_img = 0;
        exp_hit = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_ready: wr_ready=%0b required 1", wr_ready);
        end
        load_bytes(200, NPIX);
        run_frame(4'd1, 4'd1, 1'b0, 20, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_miss();
        test_timeout();
        test_saturation();
        test_partial_load();
        test_clear_stats();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
